// File: rtl/replay_loading_bar.sv
// replay_loading_bar
//   Segmented "loading" bar for a 96x64 RGB565 OLED. A small FSM
//   (IDLE/FILLING/FULL) fills NUM_SEG segments, one every TICKS_PER_SEG
//   frame ticks. Once the bar is full, the segments blink every
//   BLINK_TICKS frame ticks. A pixel renderer turns (x,y) into a
//   registered colour.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   x, y       pixel coordinate being scanned (x 0..95, y 0..63)
//   frame_tick one-cycle pulse per display frame
//   start      one-cycle request to begin filling
//   cancel     one-cycle request to abort and clear (wins over start)
//   oled_data  registered RGB565 colour for the (x,y) of the previous cycle
//   busy       high while filling
//   done       one-cycle pulse as the last segment fills
//   seg_count  number of filled segments, 0..NUM_SEG
module replay_loading_bar #(
    parameter int          NUM_SEG       = 4,
    parameter int          TICKS_PER_SEG = 30,
    parameter int          BLINK_TICKS   = 15,
    parameter int          BAR_X0        = 10,
    parameter int          BAR_X1        = 89,
    parameter int          BAR_Y0        = 26,
    parameter int          BAR_Y1        = 49,
    parameter logic [15:0] FG            = 16'h0000,
    parameter logic [15:0] BG            = 16'hFFFF,
    parameter logic [15:0] FILL          = 16'hAFE5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        cancel,
    output logic [15:0] oled_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  seg_count
);

    // Counters only ever hold 0..N-1 because they clear on the Nth tick.
    localparam int TW = (TICKS_PER_SEG > 1) ? $clog2(TICKS_PER_SEG) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEG - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);
    localparam logic [3:0]    SEG_LAST   = 4'(NUM_SEG - 1);

    // Inner fill area geometry
    localparam int IX0   = BAR_X0 + 4;
    localparam int IW    = BAR_X1 - BAR_X0 - 7;
    localparam int SEG_W = IW / NUM_SEG;
    localparam int IY0   = BAR_Y0 + 4;
    localparam int IY1   = BAR_Y1 - 4;

    typedef enum logic [1:0] {IDLE, FILLING, FULL} state_t;

    state_t        state, state_n;
    logic [3:0]    seg_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_vis, blink_vis_n;
    logic          done_n;

    int            xi, yi;
    logic          outline, seg_hit;
    logic [15:0]   color;

    // Next-state logic; cancel overrides everything else in the cycle.
    always_comb begin
        state_n     = state;
        seg_n       = seg_count;
        tick_n      = tick_cnt;
        blink_cnt_n = blink_cnt;
        blink_vis_n = blink_vis;
        done_n      = 1'b0;
        if (cancel) begin
            state_n     = IDLE;
            seg_n       = '0;
            tick_n      = '0;
            blink_cnt_n = '0;
            blink_vis_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = FILLING;
                        seg_n   = '0;
                        tick_n  = '0;
                    end
                end
                FILLING: begin
                    // start is deliberately ignored here
                    if (frame_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_n = '0;
                            seg_n  = seg_count + 4'd1;
                            if (seg_count == SEG_LAST) begin
                                state_n     = FULL;
                                done_n      = 1'b1;
                                blink_cnt_n = '0;
                                blink_vis_n = 1'b1;
                            end
                        end else begin
                            tick_n = tick_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        state_n     = FILLING;
                        seg_n       = '0;
                        tick_n      = '0;
                        blink_cnt_n = '0;
                        blink_vis_n = 1'b1;
                    end else if (BLINK_TICKS > 0 && frame_tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_n = '0;
                            blink_vis_n = ~blink_vis;
                        end else begin
                            blink_cnt_n = blink_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_count <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            blink_vis <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            oled_data <= BG;
        end else begin
            seg_count <= seg_n;
            tick_cnt  <= tick_n;
            blink_cnt <= blink_cnt_n;
            blink_vis <= blink_vis_n;
            busy      <= (state_n == FILLING);
            done      <= done_n;
            oled_data <= color;
        end
    end

    // Pixel renderer: priority outline > filled segment > background.
    assign xi = int'({25'd0, x});
    assign yi = int'({26'd0, y});

    always_comb begin
        outline = (((xi >= BAR_X0 && xi <= BAR_X0 + 2) || (xi >= BAR_X1 - 2 && xi <= BAR_X1))
                   && yi >= BAR_Y0 + 3 && yi <= BAR_Y1 - 3)
               || (((yi >= BAR_Y0 && yi <= BAR_Y0 + 2) || (yi >= BAR_Y1 - 2 && yi <= BAR_Y1))
                   && xi >= BAR_X0 + 3 && xi <= BAR_X1 - 3);
        seg_hit = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            // last column of each segment slot is left blank as a gap
            if (i < int'({28'd0, seg_count}) && yi >= IY0 && yi <= IY1
                && xi >= IX0 + i * SEG_W && xi <= IX0 + (i + 1) * SEG_W - 2) begin
                seg_hit = 1'b1;
            end
        end
        if (outline) begin
            color = FG;
        end else if (seg_hit && blink_vis) begin
            color = FILL;
        end else begin
            color = BG;
        end
    end

endmodule

// File: tb/tb_replay_loading_bar.sv
// Directed testbench for replay_loading_bar with TICKS_PER_SEG=2,
// BLINK_TICKS=2, NUM_SEG=4 and default bar geometry/colours.
module tb_replay_loading_bar;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        frame_tick;
    logic        start;
    logic        cancel;
    logic [15:0] oled_data;
    logic        busy;
    logic        done;
    logic [3:0]  seg_count;

    int errors = 0;
    int checks = 0;

    replay_loading_bar #(
        .NUM_SEG(4),
        .TICKS_PER_SEG(2),
        .BLINK_TICKS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .x(x),
        .y(y),
        .frame_tick(frame_tick),
        .start(start),
        .cancel(cancel),
        .oled_data(oled_data),
        .busy(busy),
        .done(done),
        .seg_count(seg_count)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle; pulse inputs are then dropped.
    task automatic cycle();
        @(posedge clk);
        #1;
        start      = 1'b0;
        cancel     = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; cancel = 1'b0; frame_tick = 1'b0;
        x = 7'd11; y = 6'd35;   // an outline pixel, so BG can only come from reset
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (seg_count !== 4'd0) begin errors++; $display("FAIL reset_seg got=%0d exp=0", seg_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (oled_data !== 16'hFFFF) begin errors++; $display("FAIL reset_oled got=%h exp=ffff", oled_data); end
        rst_n = 1'b1; start = 1'b0;
        x = 7'd20; y = 6'd35;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_fill();
        start = 1'b1;
        cycle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy0 got=%b exp=1", busy); end
        checks++; if (seg_count !== 4'd0) begin errors++; $display("FAIL fill_seg0 got=%0d exp=0", seg_count); end
        for (int k = 1; k <= 8; k++) begin
            frame_tick = 1'b1;
            cycle();
            checks++; if (seg_count !== 4'(k / 2)) begin errors++; $display("FAIL fill_seg tick=%0d got=%0d exp=%0d", k, seg_count, k / 2); end
            checks++; if (done !== (k == 8)) begin errors++; $display("FAIL fill_done tick=%0d got=%b exp=%b", k, done, k == 8); end
            checks++; if (busy !== (k != 8)) begin errors++; $display("FAIL fill_busy tick=%0d got=%b exp=%b", k, busy, k != 8); end
        end
        cycle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_clear got=%b exp=0", done); end
        checks++; if (seg_count !== 4'd4) begin errors++; $display("FAIL full_hold got=%0d exp=4", seg_count); end
        checks++; if (oled_data !== 16'hAFE5) begin errors++; $display("FAIL full_oled got=%h exp=afe5", oled_data); end
    endtask

    // Enters with the bar FULL, zero blink ticks seen, pixel (20,35) selected.
    task automatic test_blink();
        logic [15:0] exp_col [4] = '{16'hAFE5, 16'hFFFF, 16'hFFFF, 16'hAFE5};
        for (int k = 0; k < 4; k++) begin
            frame_tick = 1'b1;
            cycle();
            cycle();
            checks++; if (oled_data !== exp_col[k]) begin errors++; $display("FAIL blink_seg tick=%0d got=%h exp=%h", k + 1, oled_data, exp_col[k]); end
            if (k == 1) begin
                x = 7'd11;
                cycle();
                checks++; if (oled_data !== 16'h0000) begin errors++; $display("FAIL blink_outline got=%h exp=0000", oled_data); end
                x = 7'd20;
                cycle();
            end
        end
        checks++; if (seg_count !== 4'd4) begin errors++; $display("FAIL blink_seg_hold got=%0d exp=4", seg_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL blink_done got=%b exp=0", done); end
    endtask

    task automatic test_restart();
        start = 1'b1;
        cycle();
        checks++; if (seg_count !== 4'd0) begin errors++; $display("FAIL restart_seg got=%0d exp=0", seg_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
        frame_tick = 1'b1;
        cycle();
        start = 1'b1;      // must not clear the half-counted tick
        cycle();
        frame_tick = 1'b1;
        cycle();
        checks++; if (seg_count !== 4'd1) begin errors++; $display("FAIL start_ignored got=%0d exp=1", seg_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_ignored_busy got=%b exp=1", busy); end
    endtask

    task automatic test_pixels();
        logic [6:0]  px [6] = '{7'd11, 7'd50, 7'd20, 7'd31, 7'd60, 7'd5};
        logic [5:0]  py [6] = '{6'd35, 6'd27, 6'd35, 6'd35, 6'd35, 6'd5};
        logic [15:0] pc [6] = '{16'h0000, 16'h0000, 16'hAFE5, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        frame_tick = 1'b1; cycle();
        frame_tick = 1'b1; cycle();
        checks++; if (seg_count !== 4'd2) begin errors++; $display("FAIL pix_seg got=%0d exp=2", seg_count); end
        for (int i = 0; i < 6; i++) begin
            x = px[i]; y = py[i];
            cycle();
            checks++; if (oled_data !== pc[i]) begin errors++; $display("FAIL pixel (%0d,%0d) got=%h exp=%h", px[i], py[i], oled_data, pc[i]); end
        end
    endtask

    task automatic test_cancel();
        frame_tick = 1'b1; cycle();
        frame_tick = 1'b1; cycle();
        checks++; if (seg_count !== 4'd3) begin errors++; $display("FAIL cancel_pre got=%0d exp=3", seg_count); end
        frame_tick = 1'b1;
        cycle();            // counter now mid-segment
        cancel = 1'b1; start = 1'b1; frame_tick = 1'b1;
        cycle();
        checks++; if (seg_count !== 4'd0) begin errors++; $display("FAIL cancel_seg got=%0d exp=0", seg_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_done got=%b exp=0", done); end
        frame_tick = 1'b1; cycle();
        frame_tick = 1'b1; cycle();
        checks++; if (seg_count !== 4'd0) begin errors++; $display("FAIL idle_ticks got=%0d exp=0", seg_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ticks_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_midfill();
        x = 7'd20; y = 6'd35;
        start = 1'b1; cycle();
        for (int k = 0; k < 3; k++) begin frame_tick = 1'b1; cycle(); end
        checks++; if (seg_count !== 4'd1) begin errors++; $display("FAIL midfill_pre got=%0d exp=1", seg_count); end
        rst_n = 1'b0; frame_tick = 1'b1; start = 1'b1;
        cycle();
        checks++; if (seg_count !== 4'd0) begin errors++; $display("FAIL midfill_rst_seg got=%0d exp=0", seg_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midfill_rst_busy got=%b exp=0", busy); end
        checks++; if (oled_data !== 16'hFFFF) begin errors++; $display("FAIL midfill_rst_oled got=%h exp=ffff", oled_data); end
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_blink();
        test_restart();
        test_pixels();
        test_cancel();
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
